fifo_uart_tx: RTL
=================

Name: fifo_uart_tx

Overview:
UART transmitter that drains the read port of an asynchronous FIFO. It sits in the FIFO read-clock domain. When enabled and the FIFO is non-empty, it pops one word, which is show-ahead data valid while the FIFO is not empty. It then serialises the word as a start/data/parity/stop frame on a single line, with back-to-back frames and no idle gap when more data is queued.

Parameters:
DATA_WIDTH, 8, width of each FIFO word and number of data bits per frame (5..9)
CLKS_PER_BIT, 16, tx_clk cycles per UART bit (>=2)
PARITY_EN, 0, 1 = insert one parity bit after the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
tx_clk  input  1  single clock; same clock as the FIFO read port
tx_rst  input  1  synchronous, active-high reset
tx_enable  input  1  1 = allowed to start new frames
fifo_rdata  input  DATA_WIDTH  FIFO show-ahead read data
fifo_empty  input  1  FIFO empty flag
fifo_ren  output  1  FIFO pop strobe, one cycle per word
uart_txd  output  1  serial line, idle high
tx_busy  output  1  1 while a frame is in progress
tx_done  output  1  one-cycle pulse on the last cycle of each frame

Behaviour:
- Reset: tx_rst is sampled on the rising edge of tx_clk. The reset applies whether a frame is in progress or not. Required values after the reset edge:
  - state IDLE; bit counter and baud counter 0; shift register 0
  - uart_txd=1, tx_busy=0, tx_done=0, fifo_ren=0
  - No pop is issued in any cycle where tx_rst=1.
- States: IDLE, START, DATA, PARITY, STOP.
- Pop condition: pop = tx_enable & !fifo_empty & (state==IDLE | last STOP cycle).
  - fifo_ren is combinational and equals pop.
  - On the same edge, fifo_rdata is captured into the shift register and the state goes to START.
  - fifo_ren is never asserted while fifo_empty=1.
- Latency: uart_txd is registered. It falls on the edge that ends the pop cycle.
- Bit timing: every bit lasts exactly CLKS_PER_BIT cycles.
  - The baud counter counts 0..CLKS_PER_BIT-1; the state or bit advances when it reaches CLKS_PER_BIT-1.
- START: uart_txd=0.
- DATA: bits are sent LSB first; the shift register shifts right once per bit.
  - Exit after DATA_WIDTH bits, to PARITY if PARITY_EN=1, else to STOP.
- PARITY: parity is computed from the captured word.
  - Even parity: uart_txd = XOR of all data bits.
  - Odd parity: uart_txd = inverted XOR of all data bits.
- STOP: uart_txd=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - tx_done=1 in the final STOP cycle.
  - Next state is START if pop is true in that cycle, else IDLE.
- Frame length: (1+DATA_WIDTH+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles.
  - 8N1 at CLKS_PER_BIT=16 gives 160 cycles.
  - Back-to-back pops are exactly one frame length apart.
- tx_busy = (state != IDLE).
- tx_enable deasserted mid-frame: the current frame completes unchanged. No further pop is issued until tx_enable=1 again.
- fifo_empty rising mid-frame: no effect on the current frame. The block returns to IDLE after STOP with uart_txd=1.
- Counter widths: baud counter is clog2(CLKS_PER_BIT) bits; bit counter is clog2(DATA_WIDTH+1) bits. No wrap beyond their terminal values.

Test Plan:
1. 8N1, CLKS_PER_BIT=16, FIFO holds 0xA5, tx_enable=1 -> one fifo_ren pulse. uart_txd sampled mid-bit reads 0,1,0,1,0,0,1,0,1,1. tx_done pulses 160 cycles after the pop cycle; tx_busy is then 0.
2. FIFO holds 0x00 then 0xFF -> two fifo_ren pulses exactly 160 cycles apart. No idle-high gap between the first stop bit and the second start bit. tx_busy stays 1 for 320 cycles.
3. PARITY_EN=1, PARITY_ODD=0, byte 0x07 -> parity bit = 1. With PARITY_ODD=1 -> parity bit = 0. Frame length is 176 cycles.
4. fifo_empty held 1 for 1000 cycles with tx_enable=1 -> fifo_ren never asserted, uart_txd=1, tx_busy=0.
5. Three bytes queued; tx_enable dropped during the first frame's DATA bit 3 -> first frame completes, only one fifo_ren pulse. Re-raising tx_enable pops the second byte the next cycle.
6. tx_rst asserted for one cycle during DATA bit 5 -> next edge gives uart_txd=1, tx_busy=0, tx_done=0. With data still queued and tx_enable=1, fifo_ren asserts the cycle after reset deasserts.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a show-ahead FIFO read port. Each word becomes a start bit,
// LSB-first data bits, an optional parity bit and stop bits; frames run back to back.
module fifo_uart_tx #(
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned PARITY_EN    = 0,
   parameter int unsigned PARITY_ODD   = 0,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                  tx_clk,
   input  logic                  tx_rst,
   input  logic                  tx_enable,
   input  logic [DATA_WIDTH-1:0] fifo_rdata,
   input  logic                  fifo_empty,
   output logic                  fifo_ren,
   output logic                  uart_txd,
   output logic                  tx_busy,
   output logic                  tx_done
);

   localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
   localparam int unsigned BitW  = $clog2(DATA_WIDTH + 1);

   localparam logic [BaudW-1:0] BaudMax  = BaudW'(CLKS_PER_BIT - 1);
   localparam logic [BitW-1:0]  DataLast = BitW'(DATA_WIDTH - 1);
   localparam logic [BitW-1:0]  StopLast = BitW'(STOP_BITS - 1);
   localparam logic             OddPar   = (PARITY_ODD != 0);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   state_e                state_q, state_d;
   logic [BaudW-1:0]      baud_q, baud_d;
   logic [BitW-1:0]       bit_q, bit_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  parity_q, parity_d;
   logic                  txd_q, txd_d;
   logic                  bit_end, last_stop, pop;

   assign bit_end   = (baud_q == BaudMax);
   assign last_stop = (state_q == StStop) && bit_end && (bit_q == StopLast);
   // Never pop during reset: the popped word would be lost when state clears.
   assign pop       = tx_enable && !fifo_empty && !tx_rst && ((state_q == StIdle) || last_stop);

   // The line is registered, so txd_d always carries the level of the bit being entered.
   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      parity_d = parity_q;
      txd_d    = txd_q;

      if (state_q != StIdle) begin
         baud_d = bit_end ? '0 : baud_q + 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            txd_d = 1'b1;
         end
         StStart: begin
            if (bit_end) begin
               state_d = StData;
               bit_d   = '0;
               txd_d   = shift_q[0];
            end
         end
         StData: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (bit_q == DataLast) begin
                  bit_d = '0;
                  if (PARITY_EN != 0) begin
                     state_d = StParity;
                     txd_d   = parity_q;
                  end else begin
                     state_d = StStop;
                     txd_d   = 1'b1;
                  end
               end else begin
                  bit_d = bit_q + 1'b1;
                  txd_d = shift_d[0];
               end
            end
         end
         StParity: begin
            if (bit_end) begin
               state_d = StStop;
               bit_d   = '0;
               txd_d   = 1'b1;
            end
         end
         StStop: begin
            if (bit_end) begin
               if (bit_q == StopLast) begin
                  state_d = StIdle;
                  bit_d   = '0;
                  txd_d   = 1'b1;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = StIdle;
            txd_d   = 1'b1;
         end
      endcase

      if (pop) begin
         state_d  = StStart;
         baud_d   = '0;
         bit_d    = '0;
         shift_d  = fifo_rdata;
         parity_d = (^fifo_rdata) ^ OddPar;
         txd_d    = 1'b0;
      end
   end

   always_ff @(posedge tx_clk) begin
      if (tx_rst) begin
         state_q  <= StIdle;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         parity_q <= 1'b0;
         txd_q    <= 1'b1;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         parity_q <= parity_d;
         txd_q    <= txd_d;
      end
   end

   assign fifo_ren = pop;
   assign uart_txd = txd_q;
   assign tx_busy  = (state_q != StIdle);
   assign tx_done  = last_stop;

endmodule
